// File: rtl/lcd_sdram_pkg.sv
// Shared definitions for the LCD resize SDRAM burst scheduler: FSM state
// type, geometry constants and the frame-bank rotation helper.
package lcd_sdram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2
   } state_t;

   localparam int BURST_LEN  = 256;
   localparam int FIFO_DEPTH = 1024;
   localparam int BANK_WORDS = 1048576;
   localparam int NUM_BANKS  = 3;
   localparam int ADDR_W     = 24;
   localparam int WR_URGENT  = 768;

   // Picks the only bank that is neither the newest complete frame nor the
   // bank the reader is currently scanning, so the writer never tears a frame.
   function automatic logic [1:0] next_wr_bank(input logic [1:0] latest,
                                                input logic [1:0] rd_bank);
      logic [1:0] pick;
      pick = 2'd0;
      for (int b = NUM_BANKS - 1; b >= 0; b--) begin
         if ((2'(b) != latest) && (2'(b) != rd_bank)) begin
            pick = 2'(b);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/lcd_bank_mgr.sv
// Triple-buffer bank manager: tracks the bank being written, the bank being
// read and the newest complete frame, and rotates them on frame events.
module lcd_bank_mgr
   import lcd_sdram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_frame_done_i,
   input  logic       rd_apply_i,
   output logic [1:0] wr_bank_o,
   output logic [1:0] rd_bank_o
);

   logic [1:0] wr_bank_q, wr_bank_d;
   logic [1:0] rd_bank_q, rd_bank_d;
   logic [1:0] latest_q,  latest_d;

   // Next-bank selection: a finished write frame becomes the newest frame,
   // and a new read frame always starts from the newest complete frame.
   always_comb begin
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      latest_d  = latest_q;
      if (wr_frame_done_i) begin
         latest_d  = wr_bank_q;
         wr_bank_d = next_wr_bank(wr_bank_q, rd_bank_q);
      end
      if (rd_apply_i) begin
         rd_bank_d = latest_d;
      end
   end

   // Bank registers; before the first complete frame the reader gets bank 2,
   // which is stale but well defined.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank_q <= 2'd0;
         rd_bank_q <= 2'd1;
         latest_q  <= 2'd2;
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         latest_q  <= latest_d;
      end
   end

   // The writer and the reader must never share a bank.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (wr_bank_q != rd_bank_q);
      end
   end

   assign wr_bank_o = wr_bank_q;
   assign rd_bank_o = rd_bank_q;

endmodule

// File: rtl/lcd_sdram_burst_sched.sv
// SDRAM burst scheduler for the LCD resize path: arbitrates write-FIFO drain
// bursts against read-FIFO fill bursts, generates burst word addresses and
// drives the controller burst handshake.
module lcd_sdram_burst_sched
   import lcd_sdram_pkg::*;
#(
   parameter int BURST_LEN  = lcd_sdram_pkg::BURST_LEN,
   parameter int FIFO_DEPTH = lcd_sdram_pkg::FIFO_DEPTH,
   parameter int ADDR_W     = lcd_sdram_pkg::ADDR_W,
   parameter int BANK_WORDS = lcd_sdram_pkg::BANK_WORDS,
   parameter int WR_URGENT  = lcd_sdram_pkg::WR_URGENT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid_i,
   input  logic [19:0]       frame_words_i,
   input  logic              wr_frame_start_i,
   input  logic              rd_frame_start_i,
   input  logic [10:0]       wr_fifo_used_i,
   input  logic [10:0]       rd_fifo_used_i,
   output logic              burst_req_o,
   output logic              burst_wr_o,
   output logic [ADDR_W-1:0] burst_addr_o,
   input  logic              burst_ack_i,
   input  logic              burst_done_i,
   output logic [1:0]        wr_bank_o,
   output logic [1:0]        rd_bank_o,
   output logic              frame_drop_o,
   output logic              busy_o
);

   localparam int          CNT_W      = 20;
   localparam int          BANK_SHIFT = $clog2(BANK_WORDS);
   localparam logic [10:0] BURST_LVL  = 11'(BURST_LEN);
   localparam logic [10:0] URGENT_LVL = 11'(WR_URGENT);
   localparam logic [10:0] RD_LIMIT   = 11'(FIFO_DEPTH - BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(BURST_LEN);

   state_t state_q, state_d;
   logic   burst_req_q, burst_req_d;
   logic   burst_wr_q, burst_wr_d;
   logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic   wr_active_q, wr_active_d;
   logic   rd_active_q, rd_active_d;
   logic   wr_pend_q, wr_pend_d;
   logic   rd_pend_q, rd_pend_d;
   logic   last_grant_wr_q, last_grant_wr_d;
   logic   frame_drop_q, frame_drop_d;

   logic   wr_ok, rd_ok, grant_wr, grant_rd;
   logic   wr_frame_done, rd_apply;
   logic [1:0] wr_bank, rd_bank;
   logic [1:0] sel_bank;
   logic [CNT_W-1:0] sel_cnt;
   logic [ADDR_W-1:0] grant_addr;

   lcd_bank_mgr u_bank_mgr (
      .clk             (clk),
      .rst             (rst),
      .wr_frame_done_i (wr_frame_done),
      .rd_apply_i      (rd_apply),
      .wr_bank_o       (wr_bank),
      .rd_bank_o       (rd_bank)
   );

   // Arbitration: an almost-full write FIFO wins outright, otherwise two
   // eligible sides take turns, otherwise the single eligible side wins.
   always_comb begin
      wr_ok = wr_active_q && cfg_valid_i && (wr_fifo_used_i >= BURST_LVL) &&
              (wr_cnt_q < frame_words_i);
      rd_ok = rd_active_q && cfg_valid_i && (rd_fifo_used_i <= RD_LIMIT) &&
              (rd_cnt_q < frame_words_i);
      grant_wr = wr_ok && ((wr_fifo_used_i >= URGENT_LVL) || !rd_ok || !last_grant_wr_q);
      grant_rd = rd_ok && !grant_wr;
      sel_bank = grant_wr ? wr_bank : rd_bank;
      sel_cnt  = grant_wr ? wr_cnt_q : rd_cnt_q;
      grant_addr = (ADDR_W'(sel_bank) << BANK_SHIFT) + ADDR_W'(sel_cnt);
   end

   // Burst FSM and frame bookkeeping; frame-start pulses are only acted on in
   // IDLE so an in-flight burst always runs to completion first. A pulse that
   // arrives while already idle is applied in that same cycle.
   always_comb begin
      state_d         = state_q;
      burst_req_d     = burst_req_q;
      burst_wr_d      = burst_wr_q;
      burst_addr_d    = burst_addr_q;
      wr_cnt_d        = wr_cnt_q;
      rd_cnt_d        = rd_cnt_q;
      wr_active_d     = wr_active_q;
      rd_active_d     = rd_active_q;
      last_grant_wr_d = last_grant_wr_q;
      frame_drop_d    = 1'b0;
      wr_pend_d       = wr_pend_q | wr_frame_start_i;
      rd_pend_d       = rd_pend_q | rd_frame_start_i;
      wr_frame_done   = 1'b0;
      rd_apply        = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_pend_d || rd_pend_d) begin
               if (wr_pend_d) begin
                  if (wr_active_q && (wr_cnt_q != '0) && (wr_cnt_q < frame_words_i)) begin
                     frame_drop_d = 1'b1;
                  end
                  wr_cnt_d    = '0;
                  wr_active_d = cfg_valid_i;
                  wr_pend_d   = 1'b0;
               end
               if (rd_pend_d) begin
                  rd_apply    = 1'b1;
                  rd_cnt_d    = '0;
                  rd_active_d = 1'b1;
                  rd_pend_d   = 1'b0;
               end
            end else if (grant_wr || grant_rd) begin
               state_d         = REQ;
               burst_req_d     = 1'b1;
               burst_wr_d      = grant_wr;
               burst_addr_d    = grant_addr;
               last_grant_wr_d = grant_wr;
            end
         end
         REQ: begin
            if (burst_ack_i) begin
               burst_req_d = 1'b0;
               state_d     = XFER;
            end
         end
         XFER: begin
            if (burst_done_i) begin
               state_d = IDLE;
               if (burst_wr_q) begin
                  wr_cnt_d = wr_cnt_q + CNT_STEP;
                  if (wr_cnt_d == frame_words_i) begin
                     wr_frame_done = 1'b1;
                     wr_active_d   = 1'b0;
                  end
               end else begin
                  rd_cnt_d = rd_cnt_q + CNT_STEP;
                  if (rd_cnt_d == frame_words_i) begin
                     rd_active_d = 1'b0;
                  end
               end
            end
         end
         default: begin
            state_d     = IDLE;
            burst_req_d = 1'b0;
         end
      endcase
   end

   // State registers; reset aborts any burst in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         burst_req_q     <= 1'b0;
         burst_wr_q      <= 1'b0;
         burst_addr_q    <= '0;
         wr_cnt_q        <= '0;
         rd_cnt_q        <= '0;
         wr_active_q     <= 1'b0;
         rd_active_q     <= 1'b0;
         wr_pend_q       <= 1'b0;
         rd_pend_q       <= 1'b0;
         last_grant_wr_q <= 1'b0;
         frame_drop_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         burst_req_q     <= burst_req_d;
         burst_wr_q      <= burst_wr_d;
         burst_addr_q    <= burst_addr_d;
         wr_cnt_q        <= wr_cnt_d;
         rd_cnt_q        <= rd_cnt_d;
         wr_active_q     <= wr_active_d;
         rd_active_q     <= rd_active_d;
         wr_pend_q       <= wr_pend_d;
         rd_pend_q       <= rd_pend_d;
         last_grant_wr_q <= last_grant_wr_d;
         frame_drop_q    <= frame_drop_d;
      end
   end

   assign burst_req_o  = burst_req_q;
   assign burst_wr_o   = burst_wr_q;
   assign burst_addr_o = burst_addr_q;
   assign wr_bank_o    = wr_bank;
   assign rd_bank_o    = rd_bank;
   assign frame_drop_o = frame_drop_q;
   assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_sdram_burst_sched.sv
// Self-checking bench for lcd_sdram_burst_sched: the bench plays the SDRAM
// controller and both FIFOs, and a transaction-level frame/bank model predicts
// every grant, address, bank selection and dropped frame.
module tb_lcd_sdram_burst_sched;

   localparam int BL  = 256;
   localparam int FD  = 1024;
   localparam int BW  = 1048576;
   localparam int URG = 768;
   localparam int FW  = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid_i = 1'b0;
   logic [19:0] frame_words_i = 20'(FW);
   logic        wr_frame_start_i = 1'b0;
   logic        rd_frame_start_i = 1'b0;
   logic [10:0] wr_fifo_used_i = 11'd0;
   logic [10:0] rd_fifo_used_i = 11'(FD);
   logic        burst_ack_i = 1'b0;
   logic        burst_done_i = 1'b0;
   logic        burst_req_o, burst_wr_o, frame_drop_o, busy_o;
   logic [23:0] burst_addr_o;
   logic [1:0]  wr_bank_o, rd_bank_o;

   int checks = 0;
   int errors = 0;
   bit abort = 1'b0;
   int drop_seen = 0;

   // Frame-level reference model
   int m_wr_cnt, m_rd_cnt, m_wr_bank, m_rd_bank, m_latest, m_drops;
   bit m_wr_active, m_rd_active, m_last_wr;

   int wu_tab [10] = '{0, 100, 255, 256, 300, 700, 767, 768, 800, 1024};

   lcd_sdram_burst_sched dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_valid_i      (cfg_valid_i),
      .frame_words_i    (frame_words_i),
      .wr_frame_start_i (wr_frame_start_i),
      .rd_frame_start_i (rd_frame_start_i),
      .wr_fifo_used_i   (wr_fifo_used_i),
      .rd_fifo_used_i   (rd_fifo_used_i),
      .burst_req_o      (burst_req_o),
      .burst_wr_o       (burst_wr_o),
      .burst_addr_o     (burst_addr_o),
      .burst_ack_i      (burst_ack_i),
      .burst_done_i     (burst_done_i),
      .wr_bank_o        (wr_bank_o),
      .rd_bank_o        (rd_bank_o),
      .frame_drop_o     (frame_drop_o),
      .busy_o           (busy_o)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Count dropped-frame pulses, sampled away from the active edge
   always @(negedge clk) begin
      if (frame_drop_o) drop_seen++;
   end

   // Safety net against a hung handshake
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      m_wr_cnt = 0; m_rd_cnt = 0;
      m_wr_bank = 0; m_rd_bank = 1; m_latest = 2;
      m_wr_active = 1'b0; m_rd_active = 1'b0; m_last_wr = 1'b0;
      m_drops = drop_seen;
   endtask

   task automatic modelWrStart(input bit cfg);
      if (m_wr_active && m_wr_cnt > 0 && m_wr_cnt < FW) m_drops++;
      m_wr_cnt = 0;
      m_wr_active = cfg;
   endtask

   task automatic modelRdStart();
      m_rd_bank = m_latest;
      m_rd_cnt = 0;
      m_rd_active = 1'b1;
   endtask

   task automatic modelComplete(input bit is_wr);
      if (is_wr) begin
         m_wr_cnt += BL;
         if (m_wr_cnt == FW) begin
            m_latest = m_wr_bank;
            m_wr_bank = 3 - m_latest - m_rd_bank;
            m_wr_active = 1'b0;
         end
      end else begin
         m_rd_cnt += BL;
         if (m_rd_cnt == FW) m_rd_active = 1'b0;
      end
   endtask

   // 0 = no grant, 1 = write, 2 = read
   function automatic int expectedGrant(input int wu, input int ru, input bit cfg);
      bit w_ok, r_ok;
      w_ok = m_wr_active && cfg && (wu >= BL) && (m_wr_cnt < FW);
      r_ok = m_rd_active && cfg && ((FD - ru) >= BL) && (m_rd_cnt < FW);
      if (w_ok && wu >= URG) return 1;
      if (w_ok && r_ok) return m_last_wr ? 2 : 1;
      if (w_ok) return 1;
      if (r_ok) return 2;
      return 0;
   endfunction

   task automatic checkIdle();
      checkOutput("idle_busy", 32'(busy_o), 32'd0);
      checkOutput("idle_wr_bank", 32'(wr_bank_o), 32'(m_wr_bank));
      checkOutput("idle_rd_bank", 32'(rd_bank_o), 32'(m_rd_bank));
      checkOutput("bank_distinct", 32'(wr_bank_o != rd_bank_o), 32'd1);
      checkOutput("drop_count", 32'(drop_seen), 32'(m_drops));
   endtask

   // Frame-start pulses delivered while the scheduler is idle
   task automatic pulseStart(input bit w, input bit r, input bit cfg);
      @(negedge clk);
      wr_fifo_used_i = 11'd0; rd_fifo_used_i = 11'(FD);
      cfg_valid_i = cfg; wr_frame_start_i = w; rd_frame_start_i = r;
      @(negedge clk);
      wr_frame_start_i = 1'b0; rd_frame_start_i = 1'b0;
      if (w) modelWrStart(cfg);
      if (r) modelRdStart();
      repeat (2) @(negedge clk);
      checkIdle();
   endtask

   // One arbitration round: present FIFO levels, expect a grant (or none),
   // run the controller handshake and optional frame pulses during XFER.
   task automatic applyStimulus(input int wu, input int ru, input bit cfg,
                                input bit pw, input bit pr, input bit with_done);
      int kind, n, waitc;
      logic [23:0] exp_addr;
      bit exp_wr, seen;
      if (abort) return;
      kind = expectedGrant(wu, ru, cfg);
      exp_wr = (kind == 1);
      exp_addr = exp_wr ? 24'(m_wr_bank * BW + m_wr_cnt) : 24'(m_rd_bank * BW + m_rd_cnt);
      @(negedge clk);
      wr_fifo_used_i = 11'(wu); rd_fifo_used_i = 11'(ru); cfg_valid_i = cfg;
      if (kind == 0) begin
         seen = 1'b0;
         repeat (5) begin
            @(negedge clk);
            if (burst_req_o) seen = 1'b1;
         end
         checkOutput("no_grant", 32'(seen), 32'd0);
         wr_fifo_used_i = 11'd0; rd_fifo_used_i = 11'(FD);
         return;
      end
      waitc = 0;
      do begin
         @(negedge clk);
         waitc++;
      end while (!burst_req_o && waitc < 3);
      checkOutput("grant_seen", 32'(burst_req_o), 32'd1);
      if (!burst_req_o) begin
         abort = 1'b1;
         return;
      end
      m_last_wr = exp_wr;
      checkOutput("grant_dir", 32'(burst_wr_o), 32'(exp_wr));
      checkOutput("grant_addr", 32'(burst_addr_o), 32'(exp_addr));
      checkOutput("req_busy", 32'(busy_o), 32'd1);
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
         burst_done_i = 1'($urandom_range(0, 1));
         @(negedge clk);
         checkOutput("req_hold", 32'({burst_req_o, burst_wr_o, burst_addr_o}),
                     32'({1'b1, exp_wr, exp_addr}));
      end
      burst_done_i = 1'b0;
      burst_ack_i = 1'b1;
      @(negedge clk);
      burst_ack_i = 1'b0;
      checkOutput("req_drop", 32'(burst_req_o), 32'd0);
      if ((pw || pr) && !with_done) begin
         wr_frame_start_i = pw; rd_frame_start_i = pr;
         @(negedge clk);
         wr_frame_start_i = 1'b0; rd_frame_start_i = 1'b0;
      end
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
         burst_ack_i = 1'($urandom_range(0, 1));
         @(negedge clk);
         checkOutput("xfer_busy", 32'(busy_o), 32'd1);
      end
      burst_ack_i = 1'b0;
      burst_done_i = 1'b1;
      wr_fifo_used_i = 11'd0; rd_fifo_used_i = 11'(FD);
      if (with_done) begin
         wr_frame_start_i = pw; rd_frame_start_i = pr;
      end
      @(negedge clk);
      burst_done_i = 1'b0; wr_frame_start_i = 1'b0; rd_frame_start_i = 1'b0;
      modelComplete(exp_wr);
      if (pw) modelWrStart(cfg);
      if (pr) modelRdStart();
      repeat (2) @(negedge clk);
      checkIdle();
   endtask

   initial begin
      int ru;
      bit rnd_pw, rnd_pr;
      resetModel();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset released");
      checkOutput("rst_req", 32'(burst_req_o), 32'd0);
      checkOutput("rst_wr", 32'(burst_wr_o), 32'd0);
      checkOutput("rst_addr", 32'(burst_addr_o), 32'd0);
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_drop", 32'(frame_drop_o), 32'd0);
      checkOutput("rst_wr_bank", 32'(wr_bank_o), 32'd0);
      checkOutput("rst_rd_bank", 32'(rd_bank_o), 32'd1);

      // Full write frame into bank 0, then rotation
      pulseStart(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(256, FD, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_wr_bank", 32'(wr_bank_o), 32'd2);
      checkOutput("t1_rd_bank", 32'(rd_bank_o), 32'd1);

      // Reader takes the newest frame; both sides alternate, then urgency
      pulseStart(1'b1, 1'b1, 1'b1);
      checkOutput("t2_rd_bank", 32'(rd_bank_o), 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(300, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(800, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(800, 0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Abandoned write frame, then a read pulse during a write transfer
      pulseStart(1'b1, 1'b0, 1'b1);
      applyStimulus(256, FD, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(256, FD, 1'b1, 1'b0, 1'b0, 1'b0);
      pulseStart(1'b1, 1'b0, 1'b1);
      applyStimulus(256, FD, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(256, 0, 1'b1, 1'b1, 1'b1, 1'b1);

      // Stray handshake strobes in IDLE are ignored
      @(negedge clk);
      burst_ack_i = 1'b1; burst_done_i = 1'b1;
      @(negedge clk);
      burst_ack_i = 1'b0; burst_done_i = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("stray_req", 32'(burst_req_o), 32'd0);
      checkIdle();

      // Randomised traffic
      for (int it = 0; it < 80 && !abort; it++) begin
         if ($urandom_range(0, 9) < 2)
            pulseStart(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 7) != 0));
         ru = ($urandom_range(0, 3) == 0) ? (768 + $urandom_range(0, 1)) : $urandom_range(0, 1024);
         rnd_pw = ($urandom_range(0, 7) == 0);
         rnd_pr = ($urandom_range(0, 5) == 0);
         applyStimulus(wu_tab[$urandom_range(0, 9)], ru, 1'($urandom_range(0, 9) != 0),
                       rnd_pw, rnd_pr, 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a request
      if (!abort) begin
         pulseStart(1'b1, 1'b1, 1'b1);
         @(negedge clk);
         wr_fifo_used_i = 11'd256; rd_fifo_used_i = 11'(FD); cfg_valid_i = 1'b1;
         for (int i = 0; i < 3 && !burst_req_o; i++) @(negedge clk);
         checkOutput("t6_req_seen", 32'(burst_req_o), 32'd1);
         rst = 1'b1;
         @(negedge clk);
         checkOutput("t6_req", 32'(burst_req_o), 32'd0);
         checkOutput("t6_wr", 32'(burst_wr_o), 32'd0);
         checkOutput("t6_addr", 32'(burst_addr_o), 32'd0);
         checkOutput("t6_busy", 32'(busy_o), 32'd0);
         checkOutput("t6_drop", 32'(frame_drop_o), 32'd0);
         checkOutput("t6_wr_bank", 32'(wr_bank_o), 32'd0);
         checkOutput("t6_rd_bank", 32'(rd_bank_o), 32'd1);
         rst = 1'b0;
         resetModel();
         applyStimulus(1024, FD, 1'b1, 1'b0, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
